// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed driver for banked 7-segment displays.
// N digits are scanned over M independent segment buses. Each scan slot starts
// with a dark blanking window, lit digits are gated by a PWM duty and a blink
// phase, and display data is double-buffered so it only changes on frame
// boundaries.

package project_pkg;
    typedef logic [4:0] code_t;

    localparam code_t CHAR_0    = 5'd0;
    localparam code_t CHAR_1    = 5'd1;
    localparam code_t CHAR_2    = 5'd2;
    localparam code_t CHAR_3    = 5'd3;
    localparam code_t CHAR_4    = 5'd4;
    localparam code_t CHAR_5    = 5'd5;
    localparam code_t CHAR_6    = 5'd6;
    localparam code_t CHAR_7    = 5'd7;
    localparam code_t CHAR_8    = 5'd8;
    localparam code_t CHAR_9    = 5'd9;
    localparam code_t CHAR_A    = 5'd10;
    localparam code_t CHAR_B    = 5'd11;
    localparam code_t CHAR_C    = 5'd12;
    localparam code_t CHAR_D    = 5'd13;
    localparam code_t CHAR_E    = 5'd14;
    localparam code_t CHAR_F    = 5'd15;
    localparam code_t CHAR_DASH = 5'd16;
    localparam code_t CHAR_BLK  = 5'd17;
endpackage

module seven_seg_scan_ctrl
    import project_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int NUM_BANKS    = 2,
    parameter int SCAN_DIV     = 2**18,
    parameter int BLANK_CYCLES = 256,
    parameter int BLINK_DIV    = 25_000_000,
    parameter int PWM_W        = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  code_t [NUM_DIGITS-1:0]        display_data,
    input  logic  [NUM_DIGITS-1:0]        dp_mask,
    input  logic  [NUM_DIGITS-1:0]        en_mask,
    input  logic  [NUM_DIGITS-1:0]        blink_mask,
    input  logic  [PWM_W-1:0]             brightness,
    input  logic                          load,
    output logic                          frame_sync,
    output logic  [NUM_DIGITS-1:0]        an,
    output logic  [NUM_BANKS-1:0][7:0]    seg
);

    localparam int DPB     = NUM_DIGITS / NUM_BANKS;
    localparam int SLOT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W   = (DPB > 1) ? $clog2(DPB) : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST   = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  BLANK_START = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(DPB - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_DIV - 1);

    // Segment pattern for a glyph code; codes outside the table stay dark.
    function automatic logic [6:0] decode(input code_t c);
        case (c)
            CHAR_0:    return 7'h3F;
            CHAR_1:    return 7'h06;
            CHAR_2:    return 7'h5B;
            CHAR_3:    return 7'h4F;
            CHAR_4:    return 7'h66;
            CHAR_5:    return 7'h6D;
            CHAR_6:    return 7'h7D;
            CHAR_7:    return 7'h07;
            CHAR_8:    return 7'h7F;
            CHAR_9:    return 7'h6F;
            CHAR_A:    return 7'h77;
            CHAR_B:    return 7'h7C;
            CHAR_C:    return 7'h39;
            CHAR_D:    return 7'h5E;
            CHAR_E:    return 7'h79;
            CHAR_F:    return 7'h71;
            CHAR_DASH: return 7'h40;
            default:   return 7'h00;
        endcase
    endfunction

    // Free-running timebase.
    logic [SLOT_W-1:0]  slot_cnt_q,  slot_cnt_d;
    logic [IDX_W-1:0]   scan_idx_q,  scan_idx_d;
    logic [PWM_W-1:0]   pwm_cnt_q,   pwm_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;

    // Pending (written by load) and active (displayed) copies of the inputs.
    code_t [NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
    logic  [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic  [NUM_DIGITS-1:0] pend_en_q, pend_en_d, act_en_q, act_en_d;
    logic  [NUM_DIGITS-1:0] pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
    logic  [PWM_W-1:0]      pend_bright_q, pend_bright_d, act_bright_q, act_bright_d;
    logic                   pend_q, pend_d;

    // Registered pin drivers.
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [NUM_BANKS-1:0][7:0] seg_q, seg_d;
    logic                      frame_sync_q, frame_sync_d;

    logic slot_last;
    logic frame_end;
    logic pwm_on;
    logic in_window;

    logic [NUM_DIGITS-1:0][7:0] digit_glyph;
    logic [NUM_DIGITS-1:0]      digit_lit;
    logic [NUM_DIGITS-1:0]      digit_sel;

    assign slot_last = (slot_cnt_q == SLOT_LAST);
    assign frame_end = slot_last && (scan_idx_q == IDX_LAST);

    // Per-digit view: pin an[g] shows data index NUM_DIGITS-1-g and is
    // scanned in slot g % DPB of its bank.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        localparam int KP = NUM_DIGITS - 1 - g;
        assign digit_glyph[g] = {act_dp_q[KP], 1'b0 | decode(act_data_q[KP])};
        assign digit_lit[g]   = act_en_q[KP] && !(act_blink_q[KP] && blink_phase_q);
        assign digit_sel[g]   = (scan_idx_q == IDX_W'(g % DPB));
    end

    // Next values of the scan, PWM and blink counters.
    always_comb begin
        slot_cnt_d    = slot_last ? '0 : slot_cnt_q + 1'b1;
        scan_idx_d    = scan_idx_q;
        if (slot_last) begin
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + 1'b1;
        end
        pwm_cnt_d     = pwm_cnt_q + 1'b1;
        blink_cnt_d   = (blink_cnt_q == BLINK_LAST) ? '0 : blink_cnt_q + 1'b1;
        blink_phase_d = (blink_cnt_q == BLINK_LAST) ? ~blink_phase_q : blink_phase_q;
    end

    // Double buffer: load fills pending; the frame boundary promotes it.
    // A load landing on the boundary goes straight to active.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_en_d     = pend_en_q;
        pend_blink_d  = pend_blink_q;
        pend_bright_d = pend_bright_q;
        pend_d        = pend_q;
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        act_en_d      = act_en_q;
        act_blink_d   = act_blink_q;
        act_bright_d  = act_bright_q;

        if (load && !frame_end) begin
            pend_data_d   = display_data;
            pend_dp_d     = dp_mask;
            pend_en_d     = en_mask;
            pend_blink_d  = blink_mask;
            pend_bright_d = brightness;
            pend_d        = 1'b1;
        end

        if (frame_end) begin
            if (load) begin
                act_data_d   = display_data;
                act_dp_d     = dp_mask;
                act_en_d     = en_mask;
                act_blink_d  = blink_mask;
                act_bright_d = brightness;
            end else if (pend_q) begin
                act_data_d   = pend_data_q;
                act_dp_d     = pend_dp_q;
                act_en_d     = pend_en_q;
                act_blink_d  = pend_blink_q;
                act_bright_d = pend_bright_q;
            end
            pend_d = 1'b0;
        end
    end

    // Pin values for the current counter state: segments follow the selected
    // digit outside blanking, anodes additionally need enable, blink and PWM.
    always_comb begin
        an_d         = '0;
        seg_d        = '0;
        pwm_on       = (pwm_cnt_q < act_bright_q) || (&act_bright_q);
        in_window    = (slot_cnt_q >= BLANK_START);
        frame_sync_d = frame_end;
        if (in_window) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int s = 0; s < DPB; s++) begin
                    if (digit_sel[b*DPB + s]) begin
                        seg_d[b] = digit_glyph[b*DPB + s];
                    end
                end
            end
            if (pwm_on) begin
                an_d = digit_sel & digit_lit;
            end
        end
    end

    // Timebase registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q    <= '0;
            scan_idx_q    <= '0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            slot_cnt_q    <= slot_cnt_d;
            scan_idx_q    <= scan_idx_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Pending and active data registers; reset shows a blank, dark display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_data_q   <= {NUM_DIGITS{CHAR_BLK}};
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            pend_blink_q  <= '0;
            pend_bright_q <= '1;
            pend_q        <= 1'b0;
            act_data_q    <= {NUM_DIGITS{CHAR_BLK}};
            act_dp_q      <= '0;
            act_en_q      <= '0;
            act_blink_q   <= '0;
            act_bright_q  <= '1;
        end else begin
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_en_q     <= pend_en_d;
            pend_blink_q  <= pend_blink_d;
            pend_bright_q <= pend_bright_d;
            pend_q        <= pend_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            act_blink_q   <= act_blink_d;
            act_bright_q  <= act_bright_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_q         <= '0;
            seg_q        <= '0;
            frame_sync_q <= 1'b0;
        end else begin
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_sync_q <= frame_sync_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_sync = frame_sync_q;

endmodule
